// File: rtl/core_msg_dispatch.sv
// rtl/core_msg_dispatch.sv - task message decoder: r0/imem writes and fenced per-core launch
// Consumes HDR, MASK, R0VEC, R0 data and instruction words, then launches the masked cores.
module core_msg_dispatch #(
   parameter int CORE_NUM   = 16,
   parameter int INSTR_SIZE = 16,
   parameter int R0_DEPTH   = 8,
   parameter int IF_WORDS   = 16,
   parameter int IMEM_AW    = 10,
   parameter int R0_AW      = $clog2(R0_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  msg_valid,
   input  logic [INSTR_SIZE-1:0] msg_data,
   output logic                  msg_ready,
   input  logic [CORE_NUM-1:0]   core_ready,
   output logic [CORE_NUM-1:0]   imem_we,
   output logic [IMEM_AW-1:0]    imem_addr,
   output logic [INSTR_SIZE-1:0] imem_data,
   output logic [CORE_NUM-1:0]   r0_we,
   output logic [R0_AW-1:0]      r0_addr,
   output logic [INSTR_SIZE-1:0] r0_data,
   output logic [CORE_NUM-1:0]   launch,
   output logic                  task_done
);
   typedef enum logic [2:0] {
      S_HDR, S_MASK, S_R0VEC, S_R0DATA, S_INSTR, S_LAUNCH, S_WAIT_ACQ
   } state_t;

   localparam logic [1:0] FENCE_ACQ = 2'd1;
   localparam logic [1:0] FENCE_REL = 2'd2;

   state_t              state;
   logic [5:0]          if_num;
   logic [1:0]          fence;
   logic [CORE_NUM-1:0] mask;
   logic [CORE_NUM-1:0] r0vec;
   logic [R0_AW-1:0]    r0_cnt;
   logic [IMEM_AW-1:0]  instr_cnt;
   logic [1:0]          acq_cnt;

   logic                accept;
   logic                collision_free;
   logic                rel_ok;
   logic [IMEM_AW-1:0]  instr_last;

   assign accept         = msg_valid & msg_ready;
   assign collision_free = (mask & ~core_ready) == '0;
   assign rel_ok         = (fence != FENCE_REL) || (&core_ready);
   assign instr_last     = IMEM_AW'(32'(if_num) * IF_WORDS - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_HDR;
         msg_ready <= 1'b1;
         if_num    <= '0;
         fence     <= '0;
         mask      <= '0;
         r0vec     <= '0;
         r0_cnt    <= '0;
         instr_cnt <= '0;
         acq_cnt   <= '0;
         imem_we   <= '0;
         imem_addr <= '0;
         imem_data <= '0;
         r0_we     <= '0;
         r0_addr   <= '0;
         r0_data   <= '0;
         launch    <= '0;
         task_done <= 1'b0;
      end else begin
         // write enables and pulses are single-cycle; address/data hold
         imem_we   <= '0;
         r0_we     <= '0;
         launch    <= '0;
         task_done <= 1'b0;
         case (state)
            S_HDR: if (accept) begin
               if_num <= msg_data[5:0];
               fence  <= msg_data[7:6];
               state  <= S_MASK;
            end
            S_MASK: if (accept) begin
               mask  <= CORE_NUM'(msg_data);
               state <= S_R0VEC;
            end
            S_R0VEC: if (accept) begin
               r0vec  <= CORE_NUM'(msg_data);
               r0_cnt <= '0;
               state  <= S_R0DATA;
            end
            S_R0DATA: if (accept) begin
               r0_we   <= mask & r0vec;
               r0_addr <= r0_cnt;
               r0_data <= msg_data;
               r0_cnt  <= r0_cnt + 1'b1;
               if (r0_cnt == R0_AW'(R0_DEPTH - 1)) begin
                  instr_cnt <= '0;
                  if (if_num == '0) begin
                     state     <= S_LAUNCH;
                     msg_ready <= 1'b0;
                  end else begin
                     state <= S_INSTR;
                  end
               end
            end
            S_INSTR: if (accept) begin
               imem_we   <= mask;
               imem_addr <= instr_cnt;
               imem_data <= msg_data;
               instr_cnt <= instr_cnt + 1'b1;
               if (instr_cnt == instr_last) begin
                  state     <= S_LAUNCH;
                  msg_ready <= 1'b0;
               end
            end
            S_LAUNCH: begin
               // an empty mask retires at once, regardless of fence
               if (mask == '0) begin
                  state     <= S_HDR;
                  msg_ready <= 1'b1;
                  task_done <= 1'b1;
               end else if (collision_free && rel_ok) begin
                  launch <= mask;
                  if (fence == FENCE_ACQ) begin
                     state   <= S_WAIT_ACQ;
                     acq_cnt <= '0;
                  end else begin
                     state     <= S_HDR;
                     msg_ready <= 1'b1;
                     task_done <= 1'b1;
                  end
               end
            end
            S_WAIT_ACQ: begin
               // cores need two cycles to drop core_ready after the launch pulse
               if (acq_cnt != 2'd2) begin
                  acq_cnt <= acq_cnt + 1'b1;
               end else if (collision_free) begin
                  state     <= S_HDR;
                  msg_ready <= 1'b1;
                  task_done <= 1'b1;
               end
            end
            default: begin
               state     <= S_HDR;
               msg_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_core_msg_dispatch.sv
// tb/tb_core_msg_dispatch.sv - self-checking bench for core_msg_dispatch
// Directed task table, fence/reset sequences and randomized tasks against a task-level model.
module tb_core_msg_dispatch;
   logic        clk = 1'b0;
   logic        reset;
   logic        msg_valid;
   logic [15:0] msg_data;
   logic        msg_ready;
   logic [15:0] core_ready;
   logic [15:0] imem_we;
   logic [9:0]  imem_addr;
   logic [15:0] imem_data;
   logic [15:0] r0_we;
   logic [2:0]  r0_addr;
   logic [15:0] r0_data;
   logic [15:0] launch;
   logic        task_done;

   always #5 clk = ~clk;

   core_msg_dispatch dut (
      .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_data(msg_data),
      .msg_ready(msg_ready), .core_ready(core_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_data(imem_data), .r0_we(r0_we),
      .r0_addr(r0_addr), .r0_data(r0_data), .launch(launch), .task_done(task_done)
   );

   typedef struct packed {
      logic [15:0] we;
      logic [9:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] hdr, mask, r0vec, r0b, ib;
      int          exp_r0, exp_im;
      logic [15:0] exp_launch;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          done_cnt = 0;
   int          since_launch = 0;
   wr_t         r0_q[$];
   wr_t         im_q[$];
   logic [15:0] launch_q[$];
   logic [1:0]  cur_fence = 2'd0;
   logic [15:0] cur_mask = 16'h0;
   logic [15:0] cr_at_edge;
   logic [15:0] cr_manual = 16'hFFFF;
   logic [15:0] auto_cr = 16'hFFFF;
   logic        auto_cores = 1'b0;
   int          busy[16];

   assign core_ready = auto_cores ? auto_cr : cr_manual;

   always @(posedge clk) cr_at_edge <= core_ready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Observed write/launch/done events plus launch and release rule checks
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (r0_we != '0) begin
            w.we = r0_we; w.addr = 10'(r0_addr); w.data = r0_data;
            r0_q.push_back(w);
         end
         if (imem_we != '0) begin
            w.we = imem_we; w.addr = imem_addr; w.data = imem_data;
            im_q.push_back(w);
         end
         if (launch != '0) begin
            launch_q.push_back(launch);
            check("launch_collision", 64'(launch & ~cr_at_edge), 64'd0);
            if (cur_fence == 2'd2) check("launch_rel_all_ready", 64'(cr_at_edge), 64'hFFFF);
            since_launch = 0;
         end else begin
            since_launch++;
         end
         if (task_done) begin
            done_cnt++;
            if (cur_fence == 2'd1 && cur_mask != '0) begin
               check("acq_release_ready", 64'(cr_at_edge & cur_mask), 64'(cur_mask));
               check("acq_release_gap", 64'(since_launch >= 3), 64'd1);
            end else begin
               check("done_with_launch", 64'(launch), 64'(cur_mask));
            end
         end
      end
   end

   // Core model: a launched core goes busy for a few cycles; cores also go busy at random
   initial begin
      int j;
      for (int i = 0; i < 16; i++) busy[i] = 0;
      forever begin
         @(negedge clk);
         if (auto_cores) begin
            for (int i = 0; i < 16; i++) begin
               if (launch[i]) busy[i] = int'($urandom_range(2, 6));
               else if (busy[i] > 0) busy[i] = busy[i] - 1;
            end
            if ($urandom_range(0, 7) == 0) begin
               j = int'($urandom_range(0, 15));
               if (busy[j] == 0) busy[j] = int'($urandom_range(1, 3));
            end
            for (int i = 0; i < 16; i++) auto_cr[i] = (busy[i] == 0);
         end
      end
   end

   task automatic send_word(input logic [15:0] w, input int gap_max);
      int c;
      msg_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      msg_valid = 1'b1;
      msg_data  = w;
      for (c = 0; c < 400 && !msg_ready; c++) @(negedge clk);
      if (!msg_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL ready_timeout: msg_ready stuck at 0, expected 1 within 400 cycles");
      end
      @(negedge clk);
      msg_valid = 1'b0;
   endtask

   task automatic send_body(input logic [15:0] hdr, mask, r0vec, r0b, ib,
                            input int n_instr, input int gap);
      cur_fence = hdr[7:6];
      cur_mask  = mask;
      send_word(hdr, gap);
      send_word(mask, gap);
      send_word(r0vec, gap);
      for (int k = 0; k < 8; k++) send_word(r0b + 16'(k), gap);
      for (int k = 0; k < n_instr; k++) send_word(ib + 16'(k), gap);
   endtask

   // Task-level model: every masked r0/imem word is written once, in order, then one launch
   task automatic run_task(input logic [15:0] hdr, mask, r0vec, r0b, ib, input int gap);
      int  n_instr;
      int  d0;
      wr_t w;
      wr_t exp_r0[$];
      wr_t exp_im[$];
      n_instr = int'(hdr[5:0]) * 16;
      d0 = done_cnt;
      r0_q.delete();
      im_q.delete();
      launch_q.delete();
      for (int k = 0; k < 8; k++) begin
         if ((mask & r0vec) != '0) begin
            w.we = mask & r0vec; w.addr = 10'(k); w.data = r0b + 16'(k);
            exp_r0.push_back(w);
         end
      end
      if (mask != '0) begin
         for (int k = 0; k < n_instr; k++) begin
            w.we = mask; w.addr = 10'(k); w.data = ib + 16'(k);
            exp_im.push_back(w);
         end
      end
      send_body(hdr, mask, r0vec, r0b, ib, n_instr, gap);
      for (int c = 0; c < 300 && done_cnt == d0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("task_done_count", 64'(done_cnt - d0), 64'd1);
      check("r0_write_count", 64'(r0_q.size()), 64'(exp_r0.size()));
      for (int i = 0; i < exp_r0.size() && i < r0_q.size(); i++)
         check("r0_write", 64'(r0_q[i]), 64'(exp_r0[i]));
      check("imem_write_count", 64'(im_q.size()), 64'(exp_im.size()));
      for (int i = 0; i < exp_im.size() && i < im_q.size(); i++)
         check("imem_write", 64'(im_q[i]), 64'(exp_im[i]));
      check("launch_count", 64'(launch_q.size()), 64'(mask != '0));
      if (launch_q.size() > 0) check("launch_value", 64'(launch_q[0]), 64'(mask));
   endtask

   initial begin
      vec_t        tbl[6];
      logic [15:0] hdr, mask, r0vec;
      int          d0;

      tbl[0] = '{16'h0001, 16'h0003, 16'h0001, 16'h0100, 16'hA000, 8, 16, 16'h0003};
      tbl[1] = '{16'h00C2, 16'h8001, 16'h0000, 16'h0110, 16'hB000, 0, 32, 16'h8001};
      tbl[2] = '{16'h0002, 16'h0000, 16'hFFFF, 16'h0120, 16'hC000, 0, 0, 16'h0000};
      tbl[3] = '{16'h0040, 16'h0000, 16'h0001, 16'h0130, 16'hD000, 0, 0, 16'h0000};
      tbl[4] = '{16'h0003, 16'hFFFF, 16'h00F0, 16'h0140, 16'hE000, 8, 48, 16'hFFFF};
      tbl[5] = '{16'h0080, 16'h0300, 16'h0100, 16'h0150, 16'hF000, 8, 0, 16'h0300};

      reset = 1'b1;
      msg_valid = 1'b0;
      msg_data = 16'h0;
      repeat (3) @(negedge clk);
      check("rst_msg_ready", 64'(msg_ready), 64'd1);
      check("rst_imem_we", 64'(imem_we), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'd0);
      check("rst_r0_we", 64'(r0_we), 64'd0);
      check("rst_r0_addr", 64'(r0_addr), 64'd0);
      check("rst_launch", 64'(launch), 64'd0);
      check("rst_task_done", 64'(task_done), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_msg_ready", 64'(msg_ready), 64'd1);

      for (int i = 0; i < 6; i++) begin
         run_task(tbl[i].hdr, tbl[i].mask, tbl[i].r0vec, tbl[i].r0b, tbl[i].ib, 1);
         check("tbl_r0_writes", 64'(r0_q.size()), 64'(tbl[i].exp_r0));
         check("tbl_imem_writes", 64'(im_q.size()), 64'(tbl[i].exp_im));
         check("tbl_launch", 64'(launch_q.size() > 0 ? launch_q[0] : 16'h0), 64'(tbl[i].exp_launch));
      end

      // Mask collision holds the launch until core 4 is idle
      cr_manual = 16'hFFEF;
      send_body(16'h0000, 16'h0010, 16'h0010, 16'h0200, 16'h0000, 0, 0);
      for (int c = 0; c < 4; c++) begin
         check("coll_hold_ready", 64'(msg_ready), 64'd0);
         check("coll_hold_launch", 64'(launch), 64'd0);
         @(negedge clk);
      end
      cr_manual = 16'hFFFF;
      @(negedge clk);
      check("coll_launch", 64'(launch), 64'h0010);
      check("coll_done", 64'(task_done), 64'd1);
      @(negedge clk);
      check("coll_ready_back", 64'(msg_ready), 64'd1);

      // Acquire fence: stream stays blocked until core 0 drops and returns
      send_body(16'h0040, 16'h0001, 16'h0001, 16'h0300, 16'h0000, 0, 0);
      @(negedge clk);
      check("acq_launch", 64'(launch), 64'h0001);
      check("acq_no_done", 64'(task_done), 64'd0);
      cr_manual = 16'hFFFE;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("acq_hold_ready", 64'(msg_ready), 64'd0);
         check("acq_hold_done", 64'(task_done), 64'd0);
      end
      cr_manual = 16'hFFFF;
      @(negedge clk);
      check("acq_done", 64'(task_done), 64'd1);
      check("acq_ready_back", 64'(msg_ready), 64'd1);

      // Release fence: every core must be idle, not just the masked one
      cr_manual = 16'hFFFD;
      send_body(16'h0080, 16'h0001, 16'h0001, 16'h0400, 16'h0000, 0, 0);
      for (int c = 0; c < 4; c++) begin
         check("rel_hold_launch", 64'(launch), 64'd0);
         check("rel_hold_ready", 64'(msg_ready), 64'd0);
         @(negedge clk);
      end
      cr_manual = 16'hFFFF;
      @(negedge clk);
      check("rel_launch", 64'(launch), 64'h0001);
      check("rel_done", 64'(task_done), 64'd1);
      @(negedge clk);

      // Reset in the middle of the instruction frame abandons the task
      launch_q.delete();
      d0 = done_cnt;
      send_body(16'h0001, 16'h0003, 16'h0001, 16'h0500, 16'h5000, 5, 0);
      check("mid_pre_imem_we", 64'(imem_we), 64'h0003);
      check("mid_pre_imem_addr", 64'(imem_addr), 64'd4);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_imem_we", 64'(imem_we), 64'd0);
      check("mid_rst_imem_addr", 64'(imem_addr), 64'd0);
      check("mid_rst_r0_we", 64'(r0_we), 64'd0);
      check("mid_rst_msg_ready", 64'(msg_ready), 64'd1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_no_launch", 64'(launch_q.size()), 64'd0);
      check("mid_no_done", 64'(done_cnt - d0), 64'd0);
      run_task(16'h0001, 16'h0006, 16'h0004, 16'h0600, 16'h6000, 0);

      // Randomized tasks with busy cores
      auto_cores = 1'b1;
      for (int t = 0; t < 40; t++) begin
         hdr   = {8'($urandom), 2'($urandom), 6'($urandom_range(0, 3))};
         mask  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
         r0vec = 16'($urandom);
         run_task(hdr, mask, r0vec, 16'($urandom), 16'($urandom), 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
